// File: rtl/div_iter_pkg.sv
// div_iter_pkg: types and constants shared by the iterative divider.
//   div_state_t : FSM state encoding (IDLE, BUSY, DONE)
//   DIV_WIDTH   : default operand width
//   DIV_CNT_W   : iteration counter width
package div_iter_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one radix-2 restoring division iteration (combinational).
// Kept separate so a higher-radix step can be swapped in.
//   i_r : partial remainder (always < i_b on entry, or i_b == 0)
//   i_q : dividend bits still to be consumed / quotient bits produced so far
//   i_b : divisor
//   o_r : next partial remainder
//   o_q : next quotient/dividend shift register
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_r,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_r,
  output logic [WIDTH-1:0] o_q
);
  // Shifted remainder needs one extra bit: 2*r+1 can exceed WIDTH bits
  // when the divisor is large.
  logic [WIDTH:0]   w_rsh;
  logic [WIDTH+1:0] w_diff;
  logic             w_ge;

  assign w_rsh  = {i_r, i_q[WIDTH-1]};
  // Extra top bit acts as the borrow: clear means w_rsh >= i_b.
  assign w_diff = {1'b0, w_rsh} - {2'b00, i_b};
  assign w_ge   = ~w_diff[WIDTH+1];

  // Either result is < i_b, so it fits back into WIDTH bits.
  assign o_r = w_ge ? WIDTH'(w_diff) : WIDTH'(w_rsh);
  assign o_q = {i_q[WIDTH-2:0], w_ge};
endmodule

// File: rtl/div_iter.sv
// div_iter: multi-cycle unsigned divider, one quotient bit per cycle.
//   clk    : clock
//   resetn : asynchronous active-low reset
//   valid  : level request, held while the divide occupies execute
//   a, b   : dividend, divisor (unsigned)
//   done   : registered result-valid
//   c      : registered {remainder, quotient}
// A held request with unchanged operands keeps the result; new operands
// with valid still high restart immediately; dropping valid aborts.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] c
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_t       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_r;
  logic [WIDTH-1:0] w_q;
  logic             w_chg;
  logic             w_last;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_r (r_r),
    .i_q (r_q),
    .i_b (r_b),
    .o_r (w_r),
    .o_q (w_q)
  );

  assign w_chg  = ({a, b} != {r_a, r_b});
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_r     <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
      done    <= 1'b0;
      c       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (valid) begin
            r_a     <= a;
            r_b     <= b;
            r_q     <= a;
            r_r     <= '0;
            r_cnt   <= '0;
            r_state <= BUSY;
          end
        end
        BUSY, DONE: begin
          if (!valid) begin
            done    <= 1'b0;
            r_state <= IDLE;
          end else if (w_chg) begin
            // Flush-and-replace: start the new divide with no idle cycle.
            r_a     <= a;
            r_b     <= b;
            r_q     <= a;
            r_r     <= '0;
            r_cnt   <= '0;
            done    <= 1'b0;
            r_state <= BUSY;
          end else if (r_state == BUSY) begin
            r_r <= w_r;
            r_q <= w_q;
            if (w_last) begin
              c       <= {w_r, w_q};
              done    <= 1'b1;
              r_state <= DONE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed test-plan cases with literal expectations plus
// randomized traffic, all outputs compared every cycle against a
// request-level model (pure a/b arithmetic + cycles since acceptance).
module tb_div_iter;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        done;
  logic [63:0] c;

  int checks = 0;
  int errors = 0;

  div_iter #(.WIDTH(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .valid  (valid),
    .a      (a),
    .b      (b),
    .done   (done),
    .c      (c)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y);
    if (y == 0) return {x, 32'hFFFF_FFFF};
    return {x % y, x / y};
  endfunction

  // Request-level model: a request is accepted on the first edge it is seen
  // (or its operands change); the result appears 32 edges later.
  logic        m_act = 1'b0;
  logic [31:0] m_a = '0, m_b = '0;
  int          m_age = 0;
  logic        m_done = 1'b0;
  logic [63:0] m_c = '0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_act = 1'b0; m_done = 1'b0; m_c = '0;
    end else if (!valid) begin
      m_act = 1'b0; m_done = 1'b0;
    end else if (!m_act || a !== m_a || b !== m_b) begin
      m_act = 1'b1; m_a = a; m_b = b; m_age = 0; m_done = 1'b0;
    end else if (!m_done) begin
      m_age++;
      if (m_age == 32) begin
        m_done = 1'b1;
        m_c    = ref_div(m_a, m_b);
      end
    end
  end

  always @(negedge clk) begin
    chk("model done", {63'd0, done}, {63'd0, m_done});
    chk("model c", c, m_c);
  end

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Present a request, then count cycles from acceptance until done.
  task automatic run_req(input logic [31:0] ta, input logic [31:0] tb_,
                         input logic [63:0] exp, input string nm);
    int n;
    @(negedge clk);
    valid = 1'b1; a = ta; b = tb_;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    chk({nm, " latency"}, 64'(n), 64'd33);
    chk({nm, " c"}, c, exp);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  initial begin
    logic [63:0] held;
    repeat (2) @(negedge clk);
    chk("reset done", {63'd0, done}, 64'd0);
    chk("reset c", c, 64'd0);
    resetn = 1'b1;
    idle(2);

    // Basic divide, then release.
    run_req(32'd100, 32'd7, 64'h00000002_0000000E, "basic");
    valid = 1'b0;
    @(negedge clk);
    chk("basic release done", {63'd0, done}, 64'd0);

    // Corner operands and divide-by-zero.
    idle(1);
    run_req(32'hFFFF_FFFF, 32'd1, 64'h00000000_FFFFFFFF, "max/1");
    idle(2);
    run_req(32'd3, 32'hFFFF_FFFF, 64'h00000003_00000000, "3/max");
    idle(2);
    run_req(32'hFFFF_FFFF, 32'hFFFF_FFFE, 64'h00000001_00000001, "max/max-1");
    idle(2);
    run_req(32'd5, 32'd0, 64'h00000005_FFFFFFFF, "div0");
    idle(2);
    chk("div0 idle done", {63'd0, done}, 64'd0);

    // Abort in cycle 10, then a fresh request.
    @(negedge clk);
    valid = 1'b1; a = 32'd100; b = 32'd7;
    @(posedge clk);
    repeat (9) @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    chk("abort done", {63'd0, done}, 64'd0);
    run_req(32'd9, 32'd3, 64'h00000000_00000003, "after abort");

    // Hold, then operand change with valid still high.
    held = c;
    repeat (5) begin
      @(negedge clk);
      chk("hold done", {63'd0, done}, 64'd1);
      chk("hold c", c, held);
    end
    run_req(32'd20, 32'd6, 64'h00000002_00000003, "operand change");
    idle(2);

    // Reset mid-operation: outputs clear without a clock edge.
    @(negedge clk);
    valid = 1'b1; a = 32'd1000; b = 32'd3;
    @(posedge clk);
    repeat (15) @(negedge clk);
    #2 resetn = 1'b0; valid = 1'b0;
    #1;
    chk("async reset done", {63'd0, done}, 64'd0);
    chk("async reset c", c, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    run_req(32'd1000, 32'd3, 64'h00000001_0000014D, "after reset");
    idle(2);

    // Randomized traffic: full divides, early aborts, operand swaps and
    // repeated identical requests; the model process does the checking.
    for (int i = 0; i < 70; i++) begin
      int hold;
      @(negedge clk);
      valid = 1'b1; a = pick(); b = pick();
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 32))
                                         : int'($urandom_range(33, 40));
      repeat (hold) @(negedge clk);
      if ($urandom_range(0, 2) != 0) begin
        valid = 1'b0; a = $urandom; b = $urandom;
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
